// File: rtl/instr_execute_if.sv
// instr_execute_if: operand/flag bundle between the operand-fetch stage,
// the execute-stage ALU and its consumers (operand store and control FSM).
// The master side drives operands, flags, opcode and the execute enable;
// the slave side (the ALU) returns the registered result and flag bytes.
interface instr_execute_if;
  logic       fsm_ie_en;
  logic [7:0] of_ie_operand_des;
  logic [7:0] of_ie_operand_des_high;
  logic [7:0] of_ie_operand_sou;
  logic [7:0] of_ie_operand_sou_high;
  logic [7:0] of_ie_flag_reg;
  logic [4:0] of_ie_operation;
  logic [7:0] ie_os_result;
  logic [7:0] ie_os_result_high;
  logic [7:0] ie_os_flag_reg;
  logic [7:0] ie_fsm_flag_reg;

  modport master (
    output fsm_ie_en,
    output of_ie_operand_des,
    output of_ie_operand_des_high,
    output of_ie_operand_sou,
    output of_ie_operand_sou_high,
    output of_ie_flag_reg,
    output of_ie_operation,
    input  ie_os_result,
    input  ie_os_result_high,
    input  ie_os_flag_reg,
    input  ie_fsm_flag_reg
  );

  modport slave (
    input  fsm_ie_en,
    input  of_ie_operand_des,
    input  of_ie_operand_des_high,
    input  of_ie_operand_sou,
    input  of_ie_operand_sou_high,
    input  of_ie_flag_reg,
    input  of_ie_operation,
    output ie_os_result,
    output ie_os_result_high,
    output ie_os_flag_reg,
    output ie_fsm_flag_reg
  );
endinterface

// File: rtl/instr_execute.sv
// instr_execute: Z80 execute-stage ALU. Computes the 8- or 16-bit result and
// the new flag byte (S Z Y H X P/V N C, bit 7 down to bit 0) for one decoded
// operation and registers them; outputs move only when fsm_ie_en is high.
module instr_execute (
  input  logic           clk,
  input  logic           reset,
  instr_execute_if.slave bus
);

  // Operation codes presented by the operand-fetch stage; 25..31 behave as NOP.
  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_ADC   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_SBC   = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_CP    = 5'd8;
  localparam logic [4:0] OP_INC   = 5'd9;
  localparam logic [4:0] OP_DEC   = 5'd10;
  localparam logic [4:0] OP_ADD16 = 5'd11;
  localparam logic [4:0] OP_ADC16 = 5'd12;
  localparam logic [4:0] OP_SBC16 = 5'd13;
  localparam logic [4:0] OP_RLC   = 5'd14;
  localparam logic [4:0] OP_RRC   = 5'd15;
  localparam logic [4:0] OP_RL    = 5'd16;
  localparam logic [4:0] OP_RR    = 5'd17;
  localparam logic [4:0] OP_SLA   = 5'd18;
  localparam logic [4:0] OP_SRA   = 5'd19;
  localparam logic [4:0] OP_SRL   = 5'd20;
  localparam logic [4:0] OP_CPL   = 5'd21;
  localparam logic [4:0] OP_NEG   = 5'd22;
  localparam logic [4:0] OP_SCF   = 5'd23;
  localparam logic [4:0] OP_CCF   = 5'd24;

  // P/V for logic ops, rotates and shifts: set when the byte has an even number of ones.
  function automatic logic parity_even(input logic [7:0] value);
    return ~(^value);
  endfunction

  // Flag byte shared by logic ops, rotates and shifts: S, Z, Y, X and parity from
  // the result, N cleared; H and C supplied by the caller.
  function automatic logic [7:0] result_flags(input logic [7:0] res, input logic half,
                                              input logic carry);
    return {res[7], (res == 8'h00), res[5], half, res[3], parity_even(res), 1'b0, carry};
  endfunction

  logic [7:0]  d_s, dh_s, s_s, sh_s, f_s;
  logic [4:0]  op_s;
  logic        cin_s;

  assign d_s   = bus.of_ie_operand_des;
  assign dh_s  = bus.of_ie_operand_des_high;
  assign s_s   = bus.of_ie_operand_sou;
  assign sh_s  = bus.of_ie_operand_sou_high;
  assign f_s   = bus.of_ie_flag_reg;
  assign op_s  = bus.of_ie_operation;
  assign cin_s = bus.of_ie_flag_reg[0];

  // ---------------------------------------------------------------------------
  // 8-bit adder/subtractor shared by ADD/ADC/SUB/SBC/CP/INC/DEC/NEG
  // ---------------------------------------------------------------------------
  logic [7:0] a8_s, b8_s, res8_s, arith8_flags_s;
  logic       c8_s, sub8_s, half8_s, ovf8_s, carry8_s;
  logic [8:0] sum8_s;

  // Pick the adder operands, carry-in and direction for the current opcode.
  always_comb begin
    a8_s   = d_s;
    b8_s   = s_s;
    c8_s   = 1'b0;
    sub8_s = 1'b0;
    case (op_s)
      OP_ADC: begin
        c8_s = cin_s;
      end
      OP_SUB, OP_CP: begin
        sub8_s = 1'b1;
      end
      OP_SBC: begin
        sub8_s = 1'b1;
        c8_s   = cin_s;
      end
      OP_INC: begin
        b8_s = 8'h01;
      end
      OP_DEC: begin
        b8_s   = 8'h01;
        sub8_s = 1'b1;
      end
      OP_NEG: begin
        a8_s   = 8'h00;
        b8_s   = d_s;
        sub8_s = 1'b1;
      end
      default: begin
        a8_s   = d_s;
        b8_s   = s_s;
        c8_s   = 1'b0;
        sub8_s = 1'b0;
      end
    endcase
  end

  // 9-bit add or subtract; bit 8 is the carry (or borrow) out of bit 7.
  always_comb begin
    if (sub8_s) begin
      sum8_s = {1'b0, a8_s} - {1'b0, b8_s} - {8'h00, c8_s};
    end else begin
      sum8_s = {1'b0, a8_s} + {1'b0, b8_s} + {8'h00, c8_s};
    end
  end

  assign res8_s   = sum8_s[7:0];
  assign carry8_s = sum8_s[8];
  // Carry/borrow into bit 4 recovered from the operand and result bits.
  assign half8_s  = a8_s[4] ^ b8_s[4] ^ res8_s[4];
  // Signed overflow: add with like signs, or subtract with unlike signs, that flips the sign.
  assign ovf8_s   = (sub8_s ? (a8_s[7] ^ b8_s[7]) : ~(a8_s[7] ^ b8_s[7])) & (a8_s[7] ^ res8_s[7]);
  assign arith8_flags_s = {res8_s[7], (res8_s == 8'h00), res8_s[5], half8_s,
                           res8_s[3], ovf8_s, sub8_s, carry8_s};

  // ---------------------------------------------------------------------------
  // 16-bit adder/subtractor for ADD16/ADC16/SBC16
  // ---------------------------------------------------------------------------
  logic [15:0] a16_s, b16_s, res16_s;
  logic [16:0] sum16_s;
  logic        c16_s, sub16_s, half16_s, ovf16_s, carry16_s;

  assign a16_s   = {dh_s, d_s};
  assign b16_s   = {sh_s, s_s};
  assign c16_s   = ((op_s == OP_ADC16) || (op_s == OP_SBC16)) ? cin_s : 1'b0;
  assign sub16_s = (op_s == OP_SBC16);

  // 17-bit add or subtract; bit 16 is the carry (or borrow) out of bit 15.
  always_comb begin
    if (sub16_s) begin
      sum16_s = {1'b0, a16_s} - {1'b0, b16_s} - {16'h0000, c16_s};
    end else begin
      sum16_s = {1'b0, a16_s} + {1'b0, b16_s} + {16'h0000, c16_s};
    end
  end

  assign res16_s   = sum16_s[15:0];
  assign carry16_s = sum16_s[16];
  // Carry/borrow into bit 12 (the 16-bit half carry).
  assign half16_s  = a16_s[12] ^ b16_s[12] ^ res16_s[12];
  assign ovf16_s   = (sub16_s ? (a16_s[15] ^ b16_s[15]) : ~(a16_s[15] ^ b16_s[15]))
                     & (a16_s[15] ^ res16_s[15]);

  // ---------------------------------------------------------------------------
  // Logic unit and rotate/shift unit (all operate on the destination byte)
  // ---------------------------------------------------------------------------
  logic [7:0] log_res_s, sh_res_s;
  logic       sh_carry_s;

  // Bitwise AND/OR/XOR result.
  always_comb begin
    case (op_s)
      OP_AND:  log_res_s = d_s & s_s;
      OP_OR:   log_res_s = d_s | s_s;
      OP_XOR:  log_res_s = d_s ^ s_s;
      default: log_res_s = d_s;
    endcase
  end

  // Rotate/shift result and the bit shifted out into C.
  always_comb begin
    case (op_s)
      OP_RLC: begin
        sh_res_s   = {d_s[6:0], d_s[7]};
        sh_carry_s = d_s[7];
      end
      OP_RRC: begin
        sh_res_s   = {d_s[0], d_s[7:1]};
        sh_carry_s = d_s[0];
      end
      OP_RL: begin
        sh_res_s   = {d_s[6:0], cin_s};
        sh_carry_s = d_s[7];
      end
      OP_RR: begin
        sh_res_s   = {cin_s, d_s[7:1]};
        sh_carry_s = d_s[0];
      end
      OP_SLA: begin
        sh_res_s   = {d_s[6:0], 1'b0};
        sh_carry_s = d_s[7];
      end
      OP_SRA: begin
        sh_res_s   = {d_s[7], d_s[7:1]};
        sh_carry_s = d_s[0];
      end
      OP_SRL: begin
        sh_res_s   = {1'b0, d_s[7:1]};
        sh_carry_s = d_s[0];
      end
      default: begin
        sh_res_s   = d_s;
        sh_carry_s = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result/flag selection and output registers
  // ---------------------------------------------------------------------------
  logic [7:0] result_d, result_high_d, flags_d;
  logic [7:0] result_q, result_high_q, flags_q;
  logic [7:0] cpl_res_s;

  assign cpl_res_s = ~d_s;

  // Select the next result bytes and flag byte for the current opcode.
  always_comb begin
    result_d      = d_s;
    result_high_d = 8'h00;
    flags_d       = f_s;
    case (op_s)
      OP_NOP: begin
        result_d = d_s;
        flags_d  = f_s;
      end
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_NEG: begin
        result_d = res8_s;
        flags_d  = arith8_flags_s;
      end
      OP_CP: begin
        // Compare: flags of the subtraction, destination passes through.
        result_d = d_s;
        flags_d  = arith8_flags_s;
      end
      OP_INC, OP_DEC: begin
        result_d = res8_s;
        flags_d  = {arith8_flags_s[7:1], cin_s};
      end
      OP_AND, OP_OR, OP_XOR: begin
        result_d = log_res_s;
        flags_d  = result_flags(log_res_s, (op_s == OP_AND), 1'b0);
      end
      OP_ADD16: begin
        // ADD16 leaves S, Z and P/V untouched.
        {result_high_d, result_d} = res16_s;
        flags_d = {f_s[7], f_s[6], res16_s[13], half16_s, res16_s[11], f_s[2], 1'b0, carry16_s};
      end
      OP_ADC16, OP_SBC16: begin
        {result_high_d, result_d} = res16_s;
        flags_d = {res16_s[15], (res16_s == 16'h0000), res16_s[13], half16_s,
                   res16_s[11], ovf16_s, sub16_s, carry16_s};
      end
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL: begin
        result_d = sh_res_s;
        flags_d  = result_flags(sh_res_s, 1'b0, sh_carry_s);
      end
      OP_CPL: begin
        result_d = cpl_res_s;
        flags_d  = {f_s[7], f_s[6], cpl_res_s[5], 1'b1, cpl_res_s[3], f_s[2], 1'b1, f_s[0]};
      end
      OP_SCF: begin
        result_d = d_s;
        flags_d  = {f_s[7], f_s[6], d_s[5], 1'b0, d_s[3], f_s[2], 1'b0, 1'b1};
      end
      OP_CCF: begin
        // Old carry moves into H, carry is inverted.
        result_d = d_s;
        flags_d  = {f_s[7], f_s[6], d_s[5], f_s[0], d_s[3], f_s[2], 1'b0, ~f_s[0]};
      end
      default: begin
        result_d      = d_s;
        result_high_d = 8'h00;
        flags_d       = f_s;
      end
    endcase
  end

  // Output registers: cleared asynchronously by reset, loaded only when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q      <= 8'h00;
      result_high_q <= 8'h00;
      flags_q       <= 8'h00;
    end else if (bus.fsm_ie_en) begin
      result_q      <= result_d;
      result_high_q <= result_high_d;
      flags_q       <= flags_d;
    end else begin
      result_q      <= result_q;
      result_high_q <= result_high_q;
      flags_q       <= flags_q;
    end
  end

  assign bus.ie_os_result      = result_q;
  assign bus.ie_os_result_high = result_high_q;
  assign bus.ie_os_flag_reg    = flags_q;
  assign bus.ie_fsm_flag_reg   = flags_q;

endmodule

// File: tb/tb_instr_execute.sv
// tb_instr_execute: directed checks of the Z80 execute ALU followed by
// randomized operations compared against an integer-arithmetic reference model.
module tb_instr_execute;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] exp_r, exp_rh, exp_f;

  instr_execute_if bus ();

  instr_execute dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] r, input logic [7:0] rh,
                         input logic [7:0] f, input logic [7:0] fmask);
    chk({tag, "_res"},   bus.ie_os_result, r);
    chk({tag, "_high"},  bus.ie_os_result_high, rh);
    chk({tag, "_flags"}, bus.ie_os_flag_reg & fmask, f & fmask);
    chk({tag, "_fsmfl"}, bus.ie_fsm_flag_reg & fmask, f & fmask);
  endtask

  task automatic apply(input logic [4:0] op, input logic [7:0] d, input logic [7:0] dh,
                       input logic [7:0] s, input logic [7:0] sh, input logic [7:0] f,
                       input logic en);
    bus.of_ie_operation        = op;
    bus.of_ie_operand_des      = d;
    bus.of_ie_operand_des_high = dh;
    bus.of_ie_operand_sou      = s;
    bus.of_ie_operand_sou_high = sh;
    bus.of_ie_flag_reg         = f;
    bus.fsm_ie_en              = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sgn8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic int sgn16(input int v);
    return (v > 32767) ? v - 65536 : v;
  endfunction

  // Reference model: Z80 rules evaluated with integer arithmetic.
  function automatic void model(input logic [4:0] op, input logic [7:0] d, input logic [7:0] dh,
                                input logic [7:0] s, input logic [7:0] sh, input logic [7:0] f,
                                output logic [7:0] r, output logic [7:0] rh, output logic [7:0] nf);
    int a, b, c, full, sv;
    logic sub, hc, cy, v;
    logic [7:0] res;
    logic [15:0] res16;
    r  = d;
    rh = 8'h00;
    nf = f;
    case (op)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10, 5'd22: begin
        a = int'(d); b = int'(s); c = 0; sub = 1'b0;
        if (op == 5'd2 || op == 5'd4) c = int'(f[0]);
        if (op == 5'd3 || op == 5'd4 || op == 5'd8 || op == 5'd10 || op == 5'd22) sub = 1'b1;
        if (op == 5'd9 || op == 5'd10) b = 1;
        if (op == 5'd22) begin a = 0; b = int'(d); end
        if (!sub) begin
          full = a + b + c;  hc = ((a % 16) + (b % 16) + c) > 15;
          cy = full > 255;   sv = sgn8(a) + sgn8(b) + c;
        end else begin
          full = a - b - c;  hc = ((a % 16) - (b % 16) - c) < 0;
          cy = full < 0;     sv = sgn8(a) - sgn8(b) - c;
        end
        res = 8'(full & 255);
        v = (sv > 127) || (sv < -128);
        nf = {res[7], res == 8'h00, res[5], hc, res[3], v, sub, cy};
        if (op == 5'd9 || op == 5'd10) nf[0] = f[0];
        if (op != 5'd8) r = res;
      end
      5'd5, 5'd6, 5'd7: begin
        res = (op == 5'd5) ? (d & s) : (op == 5'd6) ? (d | s) : (d ^ s);
        r = res;
        nf = {res[7], res == 8'h00, res[5], op == 5'd5, res[3], ($countones(res) % 2) == 0, 1'b0, 1'b0};
      end
      5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20: begin
        a = int'(d);
        case (op)
          5'd14:   begin cy = d[7]; res = 8'((a * 2 + a / 128) % 256); end
          5'd15:   begin cy = d[0]; res = 8'(a / 2 + (a % 2) * 128); end
          5'd16:   begin cy = d[7]; res = 8'((a * 2 + int'(f[0])) % 256); end
          5'd17:   begin cy = d[0]; res = 8'(a / 2 + int'(f[0]) * 128); end
          5'd18:   begin cy = d[7]; res = 8'((a * 2) % 256); end
          5'd19:   begin cy = d[0]; res = 8'(a / 2 + (a / 128) * 128); end
          default: begin cy = d[0]; res = 8'(a / 2); end
        endcase
        r = res;
        nf = {res[7], res == 8'h00, res[5], 1'b0, res[3], ($countones(res) % 2) == 0, 1'b0, cy};
      end
      5'd21: begin
        res = 8'(255 - int'(d));
        r = res;
        nf = {f[7], f[6], res[5], 1'b1, res[3], f[2], 1'b1, f[0]};
      end
      5'd23: nf = {f[7], f[6], d[5], 1'b0, d[3], f[2], 1'b0, 1'b1};
      5'd24: nf = {f[7], f[6], d[5], f[0], d[3], f[2], 1'b0, ~f[0]};
      5'd11, 5'd12, 5'd13: begin
        a = int'({dh, d}); b = int'({sh, s});
        c = (op == 5'd11) ? 0 : int'(f[0]);
        sub = (op == 5'd13);
        if (!sub) begin
          full = a + b + c;  hc = ((a % 4096) + (b % 4096) + c) > 4095;
          cy = full > 65535; sv = sgn16(a) + sgn16(b) + c;
        end else begin
          full = a - b - c;  hc = ((a % 4096) - (b % 4096) - c) < 0;
          cy = full < 0;     sv = sgn16(a) - sgn16(b) - c;
        end
        res16 = 16'(full & 65535);
        v = (sv > 32767) || (sv < -32768);
        r  = res16[7:0];
        rh = res16[15:8];
        if (op == 5'd11)
          nf = {f[7], f[6], res16[13], hc, res16[11], f[2], 1'b0, cy};
        else
          nf = {res16[15], res16 == 16'h0000, res16[13], hc, res16[11], v, sub, cy};
      end
      default: begin
        r  = d;
        nf = f;
      end
    endcase
  endfunction

  initial begin
    logic [4:0] op;
    logic [7:0] d, dh, s, sh, f;
    logic en;
    checks = 0;
    errors = 0;

    // Reset asserted from time zero: outputs cleared, even with enable and a clock edge.
    reset = 1'b0;
    apply(5'd1, 8'd125, 8'h00, 8'd100, 8'h00, 8'h00, 1'b1);
    #2;
    chk_all("reset_init", 8'h00, 8'h00, 8'h00, 8'hFF);
    step();
    chk_all("reset_dominates_en", 8'h00, 8'h00, 8'h00, 8'hFF);
    reset = 1'b1;

    // Directed arithmetic cases.
    apply(5'd1, 8'd125, 8'h00, 8'd100, 8'h00, 8'h00, 1'b1); step();
    chk_all("add_125_100", 8'hE1, 8'h00, 8'hB4, 8'hFF);
    apply(5'd2, 8'd127, 8'h00, 8'd126, 8'h00, 8'hFF, 1'b1); step();
    chk_all("adc_127_126", 8'hFE, 8'h00, 8'hBC, 8'hFF);
    apply(5'd3, 8'd125, 8'h00, 8'd124, 8'h00, 8'h00, 1'b1); step();
    chk_all("sub_125_124", 8'h01, 8'h00, 8'h02, 8'hFF);
    apply(5'd4, 8'd124, 8'h00, 8'd124, 8'h00, 8'hFF, 1'b1); step();
    chk_all("sbc_124_124", 8'hFF, 8'h00, 8'hBB, 8'hFF);
    apply(5'd3, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 1'b1); step();
    chk_all("sub_00_80", 8'h80, 8'h00, 8'h87, 8'hFF);
    apply(5'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1); step();
    chk_all("sub_0_0", 8'h00, 8'h00, 8'h42, 8'hFF);
    apply(5'd8, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 1'b1); step();
    chk_all("cp_equal", 8'h10, 8'h00, 8'h42, 8'hFF);
    apply(5'd12, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h01, 1'b1); step();
    chk_all("adc16_7fff", 8'h00, 8'h80, 8'h94, 8'hD7);
    apply(5'd9, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1); step();
    chk_all("inc_ff_keep_c", 8'h00, 8'h00, 8'h51, 8'hFF);

    // Enable low: inputs change, outputs hold.
    apply(5'd1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0); step();
    apply(5'd7, 8'h5A, 8'h33, 8'hC3, 8'h44, 8'hFF, 1'b0); step();
    chk_all("hold_en_low", 8'h00, 8'h00, 8'h51, 8'hFF);

    // Reset mid-stream clears outputs without a clock edge.
    apply(5'd1, 8'h0F, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1); step();
    chk_all("pre_reset_add", 8'h10, 8'h00, 8'h10, 8'hFF);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 8'h00, 8'h00, 8'hFF);
    step();
    chk_all("reset_held_edge", 8'h00, 8'h00, 8'h00, 8'hFF);
    reset = 1'b1;

    // Randomized operations with random enable against the reference model.
    exp_r  = 8'h00;
    exp_rh = 8'h00;
    exp_f  = 8'h00;
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(31, 0));
      d  = 8'($urandom_range(255, 0));
      dh = 8'($urandom_range(255, 0));
      s  = 8'($urandom_range(255, 0));
      sh = 8'($urandom_range(255, 0));
      f  = 8'($urandom_range(255, 0));
      en = ($urandom_range(3, 0) != 0);
      apply(op, d, dh, s, sh, f, en);
      if (en) model(op, d, dh, s, sh, f, exp_r, exp_rh, exp_f);
      step();
      chk_all($sformatf("rand%0d_op%0d", i, op), exp_r, exp_rh, exp_f, 8'hFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
